akari_core: RTL and testbench

Top-level serial I/O block of the akari board design. Receives 8N1 UART bytes on `rxd`, keeps the last three received bytes as six hex digits on six active-low 7-segment displays, and optionally echoes each received byte back on `txd`. Everything runs in a single clock domain; no other clock enters the block.

---
 rtl/akari_pkg.sv | 53 +++++
 rtl/akari_if.sv | 35 +++
 rtl/akari_uart_rx.sv | 136 +++++++++++++
 rtl/akari_core.sv | 164 ++++++++++++++++
 tb/tb_akari_core.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/akari_pkg.sv
`default_nettype none
// ============================================================================
// Module      : akari_pkg
// Description : Shared types and constants for the akari serial I/O block:
//               RX/TX state encodings, default bit period and the
//               hex-to-7-segment (active-low) decode function.
// Revision    : 1.0 - initial release
// ============================================================================
package akari_pkg;

    // Default core clock cycles per UART bit.
    localparam int c_CLKS_PER_BIT_DEF = 40;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // Active-low segment pattern, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/akari_if.sv
`default_nettype none
// ============================================================================
// Module      : akari_if
// Description : Board-side pin bundle of the akari serial I/O block.
//               master : board/environment side (drives rxd)
//               slave  : akari_core side (drives txd and the six displays)
// Signals     : rxd (UART in), txd (UART out), segment7_1..segment7_6
//               (active-low 7-segment, segment7_1 = least-significant digit)
// Revision    : 1.0 - initial release
// ============================================================================
interface akari_if;
    logic       rxd;
    logic       txd;
    logic [6:0] segment7_1;
    logic [6:0] segment7_2;
    logic [6:0] segment7_3;
    logic [6:0] segment7_4;
    logic [6:0] segment7_5;
    logic [6:0] segment7_6;

    modport master (
        output rxd,
        input  txd,
        input  segment7_1, segment7_2, segment7_3,
        input  segment7_4, segment7_5, segment7_6
    );

    modport slave (
        input  rxd,
        output txd,
        output segment7_1, segment7_2, segment7_3,
        output segment7_4, segment7_5, segment7_6
    );
endinterface
`default_nettype wire

// File: rtl/akari_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : akari_uart_rx
// Description : 8N1 UART receiver with 2-flop input synchronizer.
//               Emits a single-cycle o_valid with o_byte for each frame whose
//               stop bit samples high; framing errors are silently dropped.
// Ports       : clk      - core clock
//               rst      - synchronous active-high reset
//               i_rxd    - asynchronous serial input, idle high
//               o_valid  - one-cycle strobe, byte received
//               o_byte   - received byte (valid with o_valid)
// Revision    : 1.0 - initial release
// ============================================================================
module akari_uart_rx
    import akari_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_CLKS_PER_BIT_DEF
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_rxd,
    output logic            o_valid,
    output logic [7:0]      o_byte
);

    localparam int              c_CW   = $clog2(CLKS_PER_BIT);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_CW-1:0] c_HALF = c_CW'(CLKS_PER_BIT / 2 - 1);

    logic            r_sync1;
    logic            r_sync2;
    rx_state_t       r_state,  w_state_d;
    logic [c_CW-1:0] r_cnt,    w_cnt_d;
    logic [2:0]      r_bit,    w_bit_d;
    logic [7:0]      r_shift,  w_shift_d;
    logic            r_ferr,   w_ferr_d;
    logic            r_valid,  w_valid_d;
    logic [7:0]      r_byte,   w_byte_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_ferr  <= 1'b0;
            r_valid <= 1'b0;
            r_byte  <= '0;
        end else begin
            r_sync1 <= i_rxd;
            r_sync2 <= r_sync1;
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_bit   <= w_bit_d;
            r_shift <= w_shift_d;
            r_ferr  <= w_ferr_d;
            r_valid <= w_valid_d;
            r_byte  <= w_byte_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_bit_d   = r_bit;
        w_shift_d = r_shift;
        w_ferr_d  = r_ferr;
        w_valid_d = 1'b0;
        w_byte_d  = r_byte;

        case (r_state)
            RX_IDLE: begin
                w_ferr_d = 1'b0;
                // Line is known high on entry, so a low level is the edge.
                if (!r_sync2) begin
                    w_state_d = RX_START;
                    w_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (r_cnt == c_HALF) begin
                    w_cnt_d = '0;
                    if (!r_sync2) begin
                        w_state_d = RX_DATA;
                        w_bit_d   = '0;
                    end else begin
                        w_state_d = RX_IDLE;
                    end
                end else begin
                    w_cnt_d = r_cnt + c_CW'(1);
                end
            end
            RX_DATA: begin
                if (r_cnt == c_LAST) begin
                    w_cnt_d   = '0;
                    w_shift_d = {r_sync2, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state_d = RX_STOP;
                    end else begin
                        w_bit_d = r_bit + 3'd1;
                    end
                end else begin
                    w_cnt_d = r_cnt + c_CW'(1);
                end
            end
            RX_STOP: begin
                if (r_ferr) begin
                    // Bad stop bit: hold here until the line recovers.
                    if (r_sync2) begin
                        w_state_d = RX_IDLE;
                        w_ferr_d  = 1'b0;
                    end
                end else if (r_cnt == c_LAST) begin
                    w_cnt_d = '0;
                    if (r_sync2) begin
                        w_valid_d = 1'b1;
                        w_byte_d  = r_shift;
                        w_state_d = RX_IDLE;
                    end else begin
                        w_ferr_d = 1'b1;
                    end
                end else begin
                    w_cnt_d = r_cnt + c_CW'(1);
                end
            end
            default: w_state_d = RX_IDLE;
        endcase
    end

    assign o_valid = r_valid;
    assign o_byte  = r_byte;

endmodule
`default_nettype wire

// File: rtl/akari_core.sv
`default_nettype none
// ============================================================================
// Module      : akari_core
// Description : akari serial I/O top. Receives 8N1 bytes, shows the last
//               three as six hex digits on active-low 7-segment displays and,
//               when AKARI_ECHO_EN is defined, echoes each byte on txd.
//               Without AKARI_ECHO_EN no TX logic exists and txd is tied high.
// Ports       : core_clk - sole clock, rising edge
//               reset    - synchronous active-high reset
//               bus      - akari_if.slave: rxd in, txd out, segment7_1..6 out
// Parameters  : CLKS_PER_BIT - core clocks per UART bit (>= 8, even)
// Revision    : 1.0 - initial release
// ============================================================================
module akari_core
    import akari_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_CLKS_PER_BIT_DEF
) (
    input  wire logic core_clk,
    input  wire logic reset,
    akari_if.slave    bus
);

    logic        w_rx_valid;
    logic [7:0]  w_rx_byte;
    logic [23:0] r_disp;
    logic [23:0] w_disp_d;
    logic [6:0]  r_seg [6];

    akari_uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk     (core_clk),
        .rst     (reset),
        .i_rxd   (bus.rxd),
        .o_valid (w_rx_valid),
        .o_byte  (w_rx_byte)
    );

    // Newest byte enters at the least-significant digits.
    assign w_disp_d = w_rx_valid ? {r_disp[15:0], w_rx_byte} : r_disp;

    always_ff @(posedge core_clk) begin
        if (reset) r_disp <= '0;
        else       r_disp <= w_disp_d;
    end

    // Segments are decoded from the next display value so the outputs
    // change together with the display register.
    for (genvar k = 0; k < 6; k++) begin : g_digit
        always_ff @(posedge core_clk) begin
            if (reset) r_seg[k] <= hex_to_seg(4'h0);
            else       r_seg[k] <= hex_to_seg(w_disp_d[4*k +: 4]);
        end
    end

    assign bus.segment7_1 = r_seg[0];
    assign bus.segment7_2 = r_seg[1];
    assign bus.segment7_3 = r_seg[2];
    assign bus.segment7_4 = r_seg[3];
    assign bus.segment7_5 = r_seg[4];
    assign bus.segment7_6 = r_seg[5];

`ifdef AKARI_ECHO_EN
    localparam int              c_CW   = $clog2(CLKS_PER_BIT);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(CLKS_PER_BIT - 1);

    logic [7:0]      r_hold,     w_hold_d;
    logic            r_pend,     w_pend_d;
    tx_state_t       r_tx_state, w_tx_state_d;
    logic [c_CW-1:0] r_tx_cnt,   w_tx_cnt_d;
    logic [2:0]      r_tx_bit,   w_tx_bit_d;
    logic [7:0]      r_tx_shift, w_tx_shift_d;
    logic            r_txd,      w_txd_d;
    logic            w_take;

    assign w_take = (r_tx_state == TX_IDLE) && r_pend;

    // A new byte wins over the take, so nothing received is lost while
    // the holding register is being emptied in the same cycle.
    assign w_hold_d = w_rx_valid ? w_rx_byte : r_hold;
    assign w_pend_d = w_rx_valid ? 1'b1 : (w_take ? 1'b0 : r_pend);

    always_ff @(posedge core_clk) begin
        if (reset) begin
            r_hold     <= '0;
            r_pend     <= 1'b0;
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_txd      <= 1'b1;
        end else begin
            r_hold     <= w_hold_d;
            r_pend     <= w_pend_d;
            r_tx_state <= w_tx_state_d;
            r_tx_cnt   <= w_tx_cnt_d;
            r_tx_bit   <= w_tx_bit_d;
            r_tx_shift <= w_tx_shift_d;
            r_txd      <= w_txd_d;
        end
    end

    always_comb begin
        w_tx_state_d = r_tx_state;
        w_tx_cnt_d   = r_tx_cnt;
        w_tx_bit_d   = r_tx_bit;
        w_tx_shift_d = r_tx_shift;
        w_txd_d      = r_txd;

        case (r_tx_state)
            TX_IDLE: begin
                w_txd_d = 1'b1;
                if (w_take) begin
                    w_tx_state_d = TX_START;
                    w_tx_cnt_d   = '0;
                    w_tx_shift_d = r_hold;
                    w_txd_d      = 1'b0;
                end
            end
            TX_START: begin
                if (r_tx_cnt == c_LAST) begin
                    w_tx_cnt_d   = '0;
                    w_tx_bit_d   = '0;
                    w_txd_d      = r_tx_shift[0];
                    w_tx_state_d = TX_DATA;
                end else begin
                    w_tx_cnt_d = r_tx_cnt + c_CW'(1);
                end
            end
            TX_DATA: begin
                if (r_tx_cnt == c_LAST) begin
                    w_tx_cnt_d   = '0;
                    w_tx_shift_d = {1'b0, r_tx_shift[7:1]};
                    if (r_tx_bit == 3'd7) begin
                        w_txd_d      = 1'b1;
                        w_tx_state_d = TX_STOP;
                    end else begin
                        w_tx_bit_d = r_tx_bit + 3'd1;
                        w_txd_d    = r_tx_shift[1];
                    end
                end else begin
                    w_tx_cnt_d = r_tx_cnt + c_CW'(1);
                end
            end
            TX_STOP: begin
                if (r_tx_cnt == c_LAST) begin
                    w_tx_cnt_d   = '0;
                    w_tx_state_d = TX_IDLE;
                end else begin
                    w_tx_cnt_d = r_tx_cnt + c_CW'(1);
                end
            end
            default: w_tx_state_d = TX_IDLE;
        endcase
    end

    assign bus.txd = r_txd;
`else
    assign bus.txd = 1'b1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_akari_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_akari_core
// Description : Directed self-checking bench for akari_core (40 clks/bit).
//               Echo checks are active when AKARI_ECHO_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_akari_core;

    localparam int CPB = 40;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    akari_if bus ();

    akari_core #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .core_clk (clk),
        .reset    (reset),
        .bus      (bus)
    );

    logic [6:0] seg [1:6];
    assign seg[1] = bus.segment7_1;
    assign seg[2] = bus.segment7_2;
    assign seg[3] = bus.segment7_3;
    assign seg[4] = bus.segment7_4;
    assign seg[5] = bus.segment7_5;
    assign seg[6] = bus.segment7_6;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] SC = 7'b1000110;
    localparam logic [6:0] SF = 7'b0001110;

`ifdef AKARI_ECHO_EN
    // Independent 8N1 decoder on txd, sampling at mid-bit.
    logic [7:0] echo_log [$];
    int         echo_fmt_err = 0;

    initial begin : echo_mon
        logic [7:0] b;
        logic       ok;
        forever begin
            @(negedge bus.txd);
            #(CPB * 5);
            ok = (bus.txd == 1'b0);
            for (int i = 0; i < 8; i++) begin
                #(CPB * 10);
                b[i] = bus.txd;
            end
            #(CPB * 10);
            ok = ok && (bus.txd == 1'b1);
            if (ok) echo_log.push_back(b);
            else    echo_fmt_err++;
        end
    end
`endif

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        bus.rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            bus.rxd = b[i];
            tick(CPB);
        end
        bus.rxd = stop_bit;
        tick(CPB);
        bus.rxd = 1'b1;
    endtask

    task automatic test_reset;
        int act;
        reset   = 1'b1;
        bus.rxd = 1'b1;
        tick(3);
        reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            checks++;
            if (seg[k] !== S0) begin
                errors++;
                $display("FAIL reset_seg%0d: got %b want %b", k, seg[k], S0);
            end
        end
        checks++;
        if (bus.txd !== 1'b1) begin
            errors++;
            $display("FAIL reset_txd: got %b want 1", bus.txd);
        end
        act = 0;
        repeat (1000) begin
            tick(1);
            if (bus.txd !== 1'b1) act++;
            for (int k = 1; k <= 6; k++) if (seg[k] !== S0) act++;
        end
        checks++;
        if (act !== 0) begin
            errors++;
            $display("FAIL idle_activity: got %0d deviations want 0", act);
        end
    endtask

    task automatic test_single;
        logic [6:0] e [1:6];
        e = '{SF, S0, S0, S0, S0, S0};
        send_byte(8'h0F, 1'b1);
        tick(CPB);
        for (int k = 1; k <= 6; k++) begin
            checks++;
            if (seg[k] !== e[k]) begin
                errors++;
                $display("FAIL single_0F_seg%0d: got %b want %b", k, seg[k], e[k]);
            end
        end
`ifdef AKARI_ECHO_EN
        tick(12 * CPB);
        checks++;
        if (echo_log.size() != 1 || echo_log[0] !== 8'h0F || echo_fmt_err != 0) begin
            errors++;
            $display("FAIL echo_0F: got n=%0d first=%h fmt_err=%0d want n=1 first=0f fmt_err=0",
                     echo_log.size(), (echo_log.size() > 0) ? echo_log[0] : 8'hxx, echo_fmt_err);
        end
`endif
    endtask

    task automatic test_back_to_back;
        logic [6:0] e [1:6];
        e = '{S8, S7, S6, S5, S4, S3};
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h78, 1'b1);
        tick(CPB);
        for (int k = 1; k <= 6; k++) begin
            checks++;
            if (seg[k] !== e[k]) begin
                errors++;
                $display("FAIL b2b_seg%0d: got %b want %b", k, seg[k], e[k]);
            end
        end
`ifdef AKARI_ECHO_EN
        tick(14 * CPB);
        checks++;
        if (echo_log.size() != 5 || echo_log[1] !== 8'h12 || echo_log[2] !== 8'h34 ||
            echo_log[3] !== 8'h56 || echo_log[4] !== 8'h78) begin
            errors++;
            $display("FAIL echo_b2b: got n=%0d want n=5 ending 12 34 56 78", echo_log.size());
        end
`endif
    endtask

    task automatic test_glitch;
        logic [6:0] e [1:6];
        e = '{S8, S7, S6, S5, S4, S3};
        bus.rxd = 1'b0;
        tick(10);
        bus.rxd = 1'b1;
        tick(20 * CPB);
        for (int k = 1; k <= 6; k++) begin
            checks++;
            if (seg[k] !== e[k]) begin
                errors++;
                $display("FAIL glitch_seg%0d: got %b want %b", k, seg[k], e[k]);
            end
        end
`ifdef AKARI_ECHO_EN
        checks++;
        if (echo_log.size() != 5) begin
            errors++;
            $display("FAIL echo_glitch: got n=%0d want 5", echo_log.size());
        end
`endif
    endtask

    task automatic test_frame_error;
        logic [6:0] e [1:6];
        send_byte(8'hA5, 1'b0);
        tick(2 * CPB);
        checks++;
        if (seg[1] !== S8 || seg[2] !== S7 || seg[6] !== S3) begin
            errors++;
            $display("FAIL ferr_unchanged: got s1=%b s2=%b s6=%b want %b %b %b",
                     seg[1], seg[2], seg[6], S8, S7, S3);
        end
        e = '{SC, S3, S8, S7, S6, S5};
        send_byte(8'h3C, 1'b1);
        tick(CPB);
        for (int k = 1; k <= 6; k++) begin
            checks++;
            if (seg[k] !== e[k]) begin
                errors++;
                $display("FAIL after_ferr_seg%0d: got %b want %b", k, seg[k], e[k]);
            end
        end
`ifdef AKARI_ECHO_EN
        tick(14 * CPB);
        checks++;
        if (echo_log.size() != 6 || echo_log[5] !== 8'h3C) begin
            errors++;
            $display("FAIL echo_ferr: got n=%0d want n=6 last=3c", echo_log.size());
        end
`endif
    endtask

    task automatic test_reset_mid_tx;
        send_byte(8'h00, 1'b1);
        tick(2 * CPB);
        checks++;
        if (seg[5] !== S8 || seg[1] !== S0) begin
            errors++;
            $display("FAIL pre_reset_disp: got s5=%b s1=%b want %b %b", seg[5], seg[1], S8, S0);
        end
`ifdef AKARI_ECHO_EN
        checks++;
        if (bus.txd !== 1'b0) begin
            errors++;
            $display("FAIL mid_tx_txd: got %b want 0", bus.txd);
        end
`endif
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        checks++;
        if (bus.txd !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_txd: got %b want 1", bus.txd);
        end
        for (int k = 1; k <= 6; k++) begin
            checks++;
            if (seg[k] !== S0) begin
                errors++;
                $display("FAIL post_reset_seg%0d: got %b want %b", k, seg[k], S0);
            end
        end
        tick(3 * CPB);
        checks++;
        if (bus.txd !== 1'b1) begin
            errors++;
            $display("FAIL txd_idle_after_reset: got %b want 1", bus.txd);
        end
    endtask

    initial begin
        reset   = 1'b1;
        bus.rxd = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_reset_mid_tx();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
